parity_deser: RTL and testbench
===============================

PARITY_DESER -- requirements
Module: parity_deser

Interface
REQ-001 SHALL have parameter width_p, default 8: number of data bits per frame (legal 1..32).
REQ-002 SHALL have parameter even_p, default 1: 1 = even parity, 0 = odd parity.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port bit_tick_i, input, 1: serial_i is sampled only in cycles where this is 1.
REQ-006 SHALL have port serial_i, input, 1: serial line, idle high.
REQ-007 SHALL have port data_o, output, width_p: received data word, LSB first on the line.
REQ-008 SHALL have port valid_o, output, 1: data_o, parity_err_o and frame_err_o are valid.
REQ-009 SHALL have port ready_i, input, 1: consumer accepts the word when valid_o && ready_i.
REQ-010 SHALL have port parity_err_o, output, 1: the word held on data_o failed the parity check.
REQ-011 SHALL have port frame_err_o, output, 1: the word held on data_o had stop bit 0.
REQ-012 SHALL have port overrun_o, output, 1: one-cycle pulse when a completed frame is dropped.

Function
REQ-013 SHALL use the frame format start(0), width_p data bits LSB first, one parity bit, stop(1), one bit per bit_tick_i.
REQ-014 SHALL implement the FSM states IDLE, DATA, PARITY, STOP; transitions occur only on bit_tick_i.
REQ-015 SHALL move IDLE->DATA on a tick that samples serial_i=0; a tick that samples 1 stays in IDLE.
REQ-016 SHALL, in DATA, shift in one bit per tick; after the width_p-th bit, go DATA->PARITY.
REQ-017 SHALL, in PARITY, sample the parity bit and go to STOP.
REQ-018 SHALL, in STOP, sample the stop bit and return to IDLE; no tick is needed between the stop bit and the next start bit.
REQ-019 SHALL compute parity as the running XOR of data and parity bits: even_p=1 flags an error if the XOR is 1; even_p=0 flags an error if it is 0.
REQ-020 SHALL set valid_o in the cycle after the stop-bit tick, and load data_o, parity_err_o and frame_err_o in that same cycle.
REQ-021 SHALL keep data_o and the error flags stable while valid_o=1 && ready_i=0.
REQ-022 SHALL clear valid_o in the cycle after valid_o && ready_i, unless a new frame completes in that same cycle, in which case the new word loads and valid_o stays 1.
REQ-023 SHALL, if a frame completes while valid_o=1 && ready_i=0, drop the new frame, keep the held word, and pulse overrun_o for one cycle.
REQ-024 SHALL still deliver a frame that has a parity or framing error (valid_o=1, error flag set); there is no resynchronisation hunt.
REQ-025 SHALL ignore serial_i entirely in cycles where bit_tick_i=0.

Reset
REQ-026 SHALL, while reset_ni=0, force FSM=IDLE, bit counter=0, shift register=0, data_o=0, valid_o=0, parity_err_o=0, frame_err_o=0, overrun_o=0.
REQ-027 SHALL abort any in-progress frame on reset without producing output; the first frame after reset release is received normally.

Structure
REQ-028 SHALL place the state enum (IDLE, DATA, PARITY, STOP) and the default width in package parity_deser_pkg.
REQ-029 SHALL use the existing xor2 module as the single sub-module, instantiated for the running-parity accumulation.
REQ-030 SHALL size the bit counter as $clog2(width_p+1) bits.

Verification
REQ-031 SHALL cover a clean frame: width_p=8, even, tick every cycle, bits 0,1,0,1,0,0,1,0,1,0,1 -> valid_o=1 one cycle after the stop tick, data_o=0xA5, both error flags 0.
REQ-032 SHALL cover a parity error: same frame with parity bit=1 -> data_o=0xA5, parity_err_o=1, frame_err_o=0.
REQ-033 SHALL cover a framing error: 0x3C with correct parity and stop bit=0 -> data_o=0x3C, frame_err_o=1.
REQ-034 SHALL cover backpressure and overrun: ready_i=0, then frames 0x11 and 0x22 back-to-back -> data_o stays 0x11, overrun_o pulses once; after ready_i=1, valid_o drops.
REQ-035 SHALL cover tick gating: bit_tick_i every 4th cycle, frame 0x80 -> data_o=0x80; toggling serial_i on non-tick cycles has no effect.
REQ-036 SHALL cover mid-frame reset: reset_ni pulsed low after 4 data bits -> no valid_o, all outputs 0; a following 0x5A frame is received correctly.

Source files
------------

// File: rtl/parity_deser_pkg.sv
// Shared types and defaults for the parity-checked serial deserialiser.
package parity_deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    localparam int WIDTH_DEFAULT = 8;

endpackage : parity_deser_pkg

// File: rtl/parity_deser_xor2.sv
// Two-input XOR cell used to accumulate the running parity of a frame.
module xor2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = a_i ^ b_i;

endmodule : xor2

// File: rtl/parity_deser.sv
// Serial deserialiser: start, width_p data bits LSB first, parity, stop; one bit per bit_tick_i.
// Output handshake: a word is offered while valid_o=1 and is consumed on any cycle with valid_o && ready_i.
module parity_deser
    import parity_deser_pkg::*;
#(
    parameter int width_p = WIDTH_DEFAULT,
    parameter int even_p  = 1
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               bit_tick_i,
    input  logic               serial_i,
    output logic [width_p-1:0] data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               parity_err_o,
    output logic               frame_err_o,
    output logic               overrun_o,
    output state_e             state_o
);

    localparam int CW = $clog2(width_p + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [width_p-1:0] shift_q, shift_d;
    logic               par_q, par_d;
    logic [width_p-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;

    logic par_xor;
    logic last_bit;
    logic frame_done;

    xor2 u_par_xor (
        .a_i (par_q),
        .b_i (serial_i),
        .y_o (par_xor)
    );

    assign last_bit   = (cnt_q == CW'(width_p - 1));
    assign frame_done = bit_tick_i && (state_q == STOP);

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every transition is gated by bit_tick_i
    always_comb begin
        state_d = state_q;
        if (bit_tick_i) begin
            case (state_q)
                IDLE:    if (!serial_i) state_d = DATA;
                DATA:    if (last_bit) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and output logic
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;

        if (bit_tick_i) begin
            case (state_q)
                IDLE: begin
                    if (!serial_i) begin
                        cnt_d = '0;
                        par_d = 1'b0;
                    end
                end
                DATA: begin
                    for (int i = 0; i < width_p - 1; i++) begin
                        shift_d[i] = shift_q[i+1];
                    end
                    shift_d[width_p-1] = serial_i;
                    par_d = par_xor;
                    cnt_d = last_bit ? '0 : cnt_q + CW'(1);
                end
                PARITY: par_d = par_xor;
                default: ;
            endcase
        end

        // A completing frame may replace a word being accepted this cycle,
        // but never a word that is still being held off by ready_i=0.
        if (frame_done) begin
            if (!valid_q || ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                perr_d  = (even_p != 0) ? par_q : !par_q;
                ferr_d  = !serial_i;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;
    assign state_o      = state_q;

endmodule : parity_deser

// File: tb/tb_parity_deser.sv
// Directed bench for parity_deser (width_p=8, even parity) with hand-computed expected words.
module tb_parity_deser;
    import parity_deser_pkg::*;

    logic       clk;
    logic       reset_ni;
    logic       bit_tick_i;
    logic       serial_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_o;
    state_e     state_o;

    int checks   = 0;
    int failures = 0;
    int ovr_cnt  = 0;
    int ovr_base;

    parity_deser #(
        .width_p (8),
        .even_p  (1)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .bit_tick_i   (bit_tick_i),
        .serial_i     (serial_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .state_o      (state_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (overrun_o) ovr_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One serial bit occupying div cycles; only the last cycle ticks.
    task automatic drive_bit(input logic b, input int div, input logic tgl);
        for (int k = 0; k < div; k++) begin
            bit_tick_i = (k == div - 1);
            serial_i   = (k == div - 1) ? b : (tgl ? ((k % 2) == 0) : 1'b1);
            step();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int div, input logic tgl, input logic rdy_stop);
        drive_bit(1'b0, div, tgl);
        for (int i = 0; i < 8; i++) drive_bit(d[i], div, tgl);
        drive_bit(p, div, tgl);
        if (rdy_stop) ready_i = 1'b1;
        drive_bit(s, div, tgl);
        bit_tick_i = 1'b0;
        serial_i   = 1'b1;
    endtask

    task automatic check_word(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        check_eq({tag, "_valid"}, 32'(valid_o), 32'd1);
        check_eq({tag, "_data"}, 32'(data_o), 32'(d));
        check_eq({tag, "_perr"}, 32'(parity_err_o), 32'(pe));
        check_eq({tag, "_ferr"}, 32'(frame_err_o), 32'(fe));
    endtask

    initial begin
        reset_ni   = 1'b0;
        bit_tick_i = 1'b0;
        serial_i   = 1'b1;
        ready_i    = 1'b0;
        repeat (3) step();
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_data", 32'(data_o), 32'd0);
        check_eq("rst_errs", {29'd0, parity_err_o, frame_err_o, overrun_o}, 32'd0);
        check_eq("rst_state", 32'(state_o), 32'(IDLE));
        reset_ni = 1'b1;
        repeat (2) step();

        // Clean frame 0xA5, even parity bit 0
        send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        check_word("clean", 8'hA5, 1'b0, 1'b0);
        repeat (2) step();
        check_word("clean_hold", 8'hA5, 1'b0, 1'b0);
        ready_i = 1'b1;
        step();
        check_eq("clean_drop", 32'(valid_o), 32'd0);

        // Parity error: same word, parity bit 1
        ready_i = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        check_word("perr", 8'hA5, 1'b1, 1'b0);
        ready_i = 1'b1;
        step();
        check_eq("perr_drop", 32'(valid_o), 32'd0);

        // Framing error: 0x3C, correct parity, stop bit 0
        ready_i = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        check_word("ferr", 8'h3C, 1'b0, 1'b1);
        ready_i = 1'b1;
        step();
        check_eq("ferr_drop", 32'(valid_o), 32'd0);

        // Backpressure and overrun: 0x11 then 0x22 back-to-back
        ready_i  = 1'b0;
        ovr_base = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        check_word("ovr", 8'h11, 1'b0, 1'b0);
        check_eq("ovr_pulse", 32'(overrun_o), 32'd1);
        step();
        check_eq("ovr_pulse_end", 32'(overrun_o), 32'd0);
        check_eq("ovr_count", 32'(ovr_cnt - ovr_base), 32'd1);
        check_word("ovr_hold", 8'h11, 1'b0, 1'b0);

        // Accept of 0x11 coincides with completion of 0x22
        send_frame(8'h22, 1'b0, 1'b1, 1, 1'b0, 1'b1);
        check_word("swap", 8'h22, 1'b0, 1'b0);
        check_eq("swap_no_ovr", 32'(overrun_o), 32'd0);
        step();
        check_eq("swap_drop", 32'(valid_o), 32'd0);

        // Tick gating: tick every 4th cycle, serial toggled between ticks
        ready_i = 1'b0;
        send_frame(8'h80, 1'b1, 1'b1, 4, 1'b1, 1'b0);
        check_word("gate", 8'h80, 1'b0, 1'b0);
        ready_i = 1'b1;
        step();
        check_eq("gate_drop", 32'(valid_o), 32'd0);

        // Mid-frame reset after 4 data bits of 0xFF
        drive_bit(1'b0, 1, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1, 1'b0);
        bit_tick_i = 1'b0;
        serial_i   = 1'b1;
        reset_ni   = 1'b0;
        #1;
        check_eq("mrst_state", 32'(state_o), 32'(IDLE));
        check_eq("mrst_outs", {22'd0, data_o, valid_o, parity_err_o, frame_err_o, overrun_o}, 32'd0);
        step();
        reset_ni = 1'b1;
        repeat (12) step();
        check_eq("mrst_no_valid", 32'(valid_o), 32'd0);
        ready_i = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        check_word("after_rst", 8'h5A, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_parity_deser
